// File: rtl/sr_cmd_gen_pkg.sv
// Shared types and defaults for the SR command generator.
// The FSM state encoding is fixed because downstream tooling decodes it.
package sr_cmd_gen_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SET_PULSE = 2'd1,
    RST_PULSE = 2'd2,
    GUARD     = 2'd3
  } sr_state_e;

  localparam int DB_CYCLES_DEF = 4;
  localparam int PULSE_LEN_DEF = 2;

endpackage

// File: rtl/sr_cmd_gen_if.sv
// Button inputs and SR command outputs of the command generator.
interface sr_cmd_gen_if;
  logic btn_set;
  logic btn_rst;
  logic S;
  logic R;
  logic busy;
  logic conflict;

  modport master (output btn_set, btn_rst, input S, R, busy, conflict);
  modport slave  (input btn_set, btn_rst, output S, R, busy, conflict);
endinterface

// File: rtl/sr_debounce.sv
// Two-flop synchronizer, consecutive-sample debouncer and rising-edge pulse
// for one raw button.
module sr_debounce
  import sr_cmd_gen_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic CLR,
  input  logic btn_i,
  output logic lvl_o,
  output logic rise_o
);

  localparam int CW = $clog2(DB_CYCLES);

  logic          sync1_q, sync2_q;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counts consecutive synchronized samples that disagree with the accepted
  // level; the DB_CYCLES-th disagreeing sample flips the level.
  always_comb begin
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    cnt_d  = '0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        lvl_d  = sync2_q;
        rise_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns debounced set/reset button presses into fixed-length, mutually
// exclusive S/R command pulses for a downstream SR flip-flop.
module sr_cmd_gen
  import sr_cmd_gen_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int PULSE_LEN = PULSE_LEN_DEF
) (
  input logic         CLK,
  input logic         CLR,
  sr_cmd_gen_if.slave bus
);

  localparam int CW = $clog2(PULSE_LEN + 1);

  logic          set_lvl, set_rise, rst_lvl, rst_rise;
  sr_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic          pend_set_q, pend_rst_q;
  logic          s_q, r_q, busy_q, conflict_q;

  sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .CLK(CLK), .CLR(CLR), .btn_i(bus.btn_set), .lvl_o(set_lvl), .rise_o(set_rise)
  );

  sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rst (
    .CLK(CLK), .CLR(CLR), .btn_i(bus.btn_rst), .lvl_o(rst_lvl), .rise_o(rst_rise)
  );

  // A rise is honoured in the same cycle it arrives so an idle FSM answers
  // one cycle after the debounced edge; otherwise it waits in the pending flag.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_set_q <= 1'b0;
      pend_rst_q <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_q | (set_lvl & rst_lvl);
      pend_set_q <= pend_set_q | set_rise;
      pend_rst_q <= pend_rst_q | rst_rise;
      case (state_q)
        // The last guard cycle dispatches like IDLE, so a queued command
        // follows the guard with no idle gap.
        IDLE, GUARD: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          s_q     <= 1'b0;
          r_q     <= 1'b0;
          busy_q  <= 1'b0;
          if (pend_rst_q | rst_rise) begin
            state_q    <= RST_PULSE;
            cnt_q      <= CW'(1);
            r_q        <= 1'b1;
            busy_q     <= 1'b1;
            pend_rst_q <= 1'b0;
          end else if (pend_set_q | set_rise) begin
            state_q    <= SET_PULSE;
            cnt_q      <= CW'(1);
            s_q        <= 1'b1;
            busy_q     <= 1'b1;
            pend_set_q <= 1'b0;
          end
        end
        SET_PULSE, RST_PULSE: begin
          if (cnt_q == CW'(PULSE_LEN)) begin
            state_q <= GUARD;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.S        = s_q;
  assign bus.R        = r_q;
  assign bus.busy     = busy_q;
  assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed and random stimulus for two sr_cmd_gen configurations, checked
// cycle by cycle against a scheduling-level reference model.
module tb_sr_cmd_gen;

  logic CLK = 1'b0;
  logic CLR = 1'b1;
  always #5 CLK = ~CLK;

  sr_cmd_gen_if if0 ();
  sr_cmd_gen_if if1 ();

  sr_cmd_gen dut0 (.CLK(CLK), .CLR(CLR), .bus(if0.slave));
  sr_cmd_gen #(.DB_CYCLES(2), .PULSE_LEN(1)) dut1 (.CLK(CLK), .CLR(CLR), .bus(if1.slave));

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Instance 0: DB=4, P=2. Instance 1: DB=2, P=1. Button index 0=set, 1=rst.
  int        PL [2] = '{2, 1};
  int        DBC[2] = '{4, 2};
  bit [15:0] hs [2][2];
  bit        db [2][2];
  bit        rs [2][2];
  bit        pd [2][2];
  bit        cf [2];
  int        cyc[2], st[2], freeat[2];
  bit        act[2], kset[2];
  bit        eS[2], eR[2], eB[2];

  always @(posedge CLK) begin
    bit btn[2][2];
    bit ps, pr, all1, all0;
    btn[0][0] = if0.btn_set; btn[0][1] = if0.btn_rst;
    btn[1][0] = if1.btn_set; btn[1][1] = if1.btn_rst;
    for (int i = 0; i < 2; i++) begin
      if (CLR) begin
        for (int b = 0; b < 2; b++) begin
          hs[i][b] = '0; db[i][b] = 0; rs[i][b] = 0; pd[i][b] = 0;
        end
        cf[i] = 0; cyc[i] = 0; st[i] = 0; freeat[i] = 0; act[i] = 0; kset[i] = 0;
        eS[i] = 0; eR[i] = 0; eB[i] = 0;
      end else begin
        cf[i] = cf[i] | (db[i][0] & db[i][1]);
        pr = pd[i][1] | rs[i][1];
        ps = pd[i][0] | rs[i][0];
        if (cyc[i] >= freeat[i]) begin
          if (pr) begin
            act[i] = 1; kset[i] = 0; st[i] = cyc[i]; freeat[i] = cyc[i] + PL[i] + 1; pr = 0;
          end else if (ps) begin
            act[i] = 1; kset[i] = 1; st[i] = cyc[i]; freeat[i] = cyc[i] + PL[i] + 1; ps = 0;
          end
        end
        pd[i][1] = pr;
        pd[i][0] = ps;
        // level accepted once the last DB synchronized samples (raw delayed 2) agree
        for (int b = 0; b < 2; b++) begin
          all1 = 1; all0 = 1;
          for (int j = 1; j <= DBC[i]; j++) begin
            if (hs[i][b][j]) all0 = 0; else all1 = 0;
          end
          rs[i][b] = 0;
          if (!db[i][b] && all1) begin db[i][b] = 1; rs[i][b] = 1; end
          else if (db[i][b] && all0) db[i][b] = 0;
          hs[i][b] = {hs[i][b][14:0], btn[i][b]};
        end
        eS[i] = act[i] && kset[i]  && (cyc[i] < st[i] + PL[i]);
        eR[i] = act[i] && !kset[i] && (cyc[i] < st[i] + PL[i]);
        eB[i] = act[i] && (cyc[i] <= st[i] + PL[i]);
        cyc[i] = cyc[i] + 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int nS0, nR0, nB0, nS1, nR1, fS, fR, tc;
  bit q1 = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    nS0 = 0; nR0 = 0; nB0 = 0; nS1 = 0; nR1 = 0; fS = -1; fR = -1; tc = 0;
  endtask

  task automatic tick();
    @(negedge CLK);
    chk("S0",    if0.S,        eS[0] & ~CLR);
    chk("R0",    if0.R,        eR[0] & ~CLR);
    chk("busy0", if0.busy,     eB[0] & ~CLR);
    chk("conf0", if0.conflict, cf[0] & ~CLR);
    chk("SR0",   if0.S & if0.R, 1'b0);
    chk("S1",    if1.S,        eS[1] & ~CLR);
    chk("R1",    if1.R,        eR[1] & ~CLR);
    chk("busy1", if1.busy,     eB[1] & ~CLR);
    chk("conf1", if1.conflict, cf[1] & ~CLR);
    chk("SR1",   if1.S & if1.R, 1'b0);
    nS0 += int'(if0.S); nR0 += int'(if0.R); nB0 += int'(if0.busy);
    nS1 += int'(if1.S); nR1 += int'(if1.R);
    if (if0.S && fS < 0) fS = tc;
    if (if0.R && fR < 0) fR = tc;
    if (if1.S) q1 = 1; else if (if1.R) q1 = 0;
    tc++;
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    if0.btn_set = 0; if0.btn_rst = 0; if1.btn_set = 0; if1.btn_rst = 0;
    clr_cnt();
    repeat (3) tick();
    chk("rst_S", if0.S, 1'b0);
    chk("rst_busy", if0.busy, 1'b0);
    CLR = 0;
    repeat (3) tick();

    // held press: one 2-cycle S pulse plus guard
    clr_cnt(); if0.btn_set = 1; repeat (10) tick(); if0.btn_set = 0; repeat (15) tick();
    chk_int("A_Scyc", nS0, 2); chk_int("A_busy", nB0, 3); chk_int("A_Rcyc", nR0, 0);

    // 3-cycle glitch is rejected
    clr_cnt(); if0.btn_set = 1; repeat (3) tick(); if0.btn_set = 0; repeat (15) tick();
    chk_int("B_Scyc", nS0, 0); chk_int("B_busy", nB0, 0);

    // simultaneous presses: R, guard, then S; conflict sticks
    clr_cnt(); if0.btn_set = 1; if0.btn_rst = 1; repeat (10) tick();
    if0.btn_set = 0; if0.btn_rst = 0; repeat (20) tick();
    chk_int("C_Scyc", nS0, 2); chk_int("C_Rcyc", nR0, 2); chk_int("C_busy", nB0, 6);
    chk_int("C_order", fS - fR, 3); chk("C_conf", if0.conflict, 1'b1);
    CLR = 1; tick(); chk("C_confclr", if0.conflict, 1'b0); CLR = 0; tick();

    // reset press accepted during the S pulse follows right after the guard
    clr_cnt(); if0.btn_set = 1; tick(); if0.btn_rst = 1; repeat (3) tick();
    if0.btn_set = 0; repeat (3) tick(); if0.btn_rst = 0; repeat (20) tick();
    chk_int("D_gap", fR - fS, 3); chk_int("D_Scyc", nS0, 2); chk_int("D_Rcyc", nR0, 2);

    // CLR in the first S cycle drops S asynchronously; no pulse afterwards
    clr_cnt(); if0.btn_set = 1; n = 0;
    while (!if0.S && n < 30) begin tick(); n++; end
    chk("E_seen", if0.S, 1'b1);
    CLR = 1; if0.btn_set = 0; #1;
    chk("E_asyncS", if0.S, 1'b0); chk("E_asyncB", if0.busy, 1'b0);
    repeat (2) tick(); CLR = 0; clr_cnt(); repeat (20) tick();
    chk_int("E_noS", nS0, 0);

    // button held through CLR release yields exactly one command
    CLR = 1; if0.btn_set = 1; repeat (2) tick(); CLR = 0; clr_cnt(); repeat (20) tick();
    chk_int("F_Scyc", nS0, 2); chk_int("F_busy", nB0, 3);
    if0.btn_set = 0; repeat (15) tick();

    // short config: alternating presses drive a downstream SR flop 1,0,1,0
    clr_cnt();
    for (int p = 0; p < 4; p++) begin
      if (p % 2 == 0) if1.btn_set = 1; else if1.btn_rst = 1;
      repeat (3) tick(); if1.btn_set = 0; if1.btn_rst = 0; repeat (17) tick();
      chk_int("G_Q", int'(q1), (p % 2 == 0) ? 1 : 0);
    end
    chk_int("G_Scyc", nS1, 2); chk_int("G_Rcyc", nR1, 2);

    // random toggling on both instances against the model
    repeat (500) begin
      if ($urandom_range(0, 9) == 0) if0.btn_set = ~if0.btn_set;
      if ($urandom_range(0, 9) == 0) if0.btn_rst = ~if0.btn_rst;
      if ($urandom_range(0, 7) == 0) if1.btn_set = ~if1.btn_set;
      if ($urandom_range(0, 7) == 0) if1.btn_rst = ~if1.btn_rst;
      tick();
    end
    if0.btn_set = 0; if0.btn_rst = 0; if1.btn_set = 0; if1.btn_rst = 0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
